step_sequencer: RTL and testbench
=================================

# step_sequencer

Parametrised multi-channel step-sequencer core for the drum machine. It holds a CHANNELS × STEPS trigger pattern and generates the step clock from a BPM value with a phase accumulator, so the tempo is exact on average. On each step it emits one-cycle trigger pulses to the sample-playback voices. It replaces the fixed four-instrument, eight-step bpm/control/datapath trio, and adds programmable loop length, per-channel mute and live pattern edits.

## Interface
Parameters:
- CHANNELS, 4, number of instrument rows / trigger outputs
- STEPS, 8, pattern length in steps (≥2)
- CLK_HZ, 50_000_000, clk frequency in Hz
- STEP_DIV, 4, steps per beat (4 = sixteenth notes)
- BPM_W, 8, width of the bpm input
- BPM_RESET, 120, bpm value after reset

Ports:
- clk  in  1  system clock; one clock domain
- reset  in  1  asynchronous, active-high; clears all state
- play  in  1  level; 1 = run, 0 = stop
- bpm  in  BPM_W  tempo value, captured on bpm_load
- bpm_load  in  1  capture bpm this cycle; a value of 0 is ignored
- wr_en  in  1  write one pattern row
- wr_chan  in  $clog2(CHANNELS)  row to write; values ≥ CHANNELS are ignored
- wr_data  in  STEPS  row contents; bit s = trigger at step s
- mute  in  CHANNELS  per-channel mute, sampled on step cycles
- loop_len  in  $clog2(STEPS)+1  active loop length; 0 or > STEPS means STEPS
- trig  out  CHANNELS  one-cycle trigger pulses
- step_idx  out  $clog2(STEPS)  current step
- step_tick  out  1  one-cycle pulse when a step starts
- bar_tick  out  1  one-cycle pulse when step 0 starts
- playing  out  1  1 while in state PLAY

## Operation
- Reset values:
  - trig=0, step_idx=0, step_tick=0, bar_tick=0, playing=0.
  - All pattern bits = 0, bpm_reg=BPM_RESET, accumulator=0, state IDLE.
- State machine:
  - IDLE: if play=1, clear the accumulator, load step 0 and go to PLAY.
  - PLAY: if play=0, go to IDLE. step_idx→0, trig/ticks→0, accumulator cleared.
  - Pausing is not supported; stop always rewinds to step 0.
- Tempo generation:
  - INC = bpm_reg × STEP_DIV; THRESH = CLK_HZ × 60. The accumulator is wide enough to hold THRESH + max INC.
  - In PLAY, every cycle: acc_next = acc + INC.
  - If acc_next ≥ THRESH: acc ← acc_next − THRESH and the step advances. Otherwise acc ← acc_next.
- Step advance:
  - eff_len = loop_len if 1 ≤ loop_len ≤ STEPS, else STEPS.
  - If step_idx ≥ eff_len−1, the next step is 0; otherwise step_idx+1.
  - Shrinking loop_len below the current position therefore wraps on the next advance.
- Trigger generation:
  - On every step start: trig[c] = pattern[c][new_step] & ~mute[c].
  - step_tick=1. bar_tick=1 iff new_step=0.
- Pattern write:
  - wr_en writes the row at the clock edge. Writes are allowed in any state.
  - A write in the same cycle as a step advance is not visible to that step's trig: read-before-write.
- bpm_load:
  - Updates bpm_reg at the edge, so the new INC applies from the next cycle.
  - acc is not cleared on a tempo change; the phase is preserved.

## Timing
- Start:
  - play seen high in IDLE at edge E.
  - At E+1: playing=1, step_idx=0, step_tick=1, bar_tick=1, trig = step-0 pattern.
- Step period (CLK_HZ=80, STEP_DIV=4, bpm=120 → INC=480, THRESH=4800): exactly 10 cycles. Steps start at E+1, E+11, E+21, …
- Non-integer ratios alternate ⌊P⌋/⌈P⌉ cycle periods. The long-run average is exact.
- Width of pulses: trig, step_tick and bar_tick are high exactly one cycle per step. They are all registered outputs.
- Stop:
  - play low at edge F.
  - At F+1: playing=0, step_idx=0, all pulses 0.
  - A step pending in the same cycle is discarded.
- Reset mid-play: all outputs return to reset values immediately (asynchronous), and the pattern is cleared.

## Test plan
- Reset and start, CLK_HZ=80, bpm=120:
  - Stimulus: write row0=8'b0001_0001; raise play.
  - Required: trig[0] pulses at E+1 and E+41; step_tick every 10 cycles; step_idx counts 0…7 and wraps; bar_tick every 80 cycles.
- Mute and live edit:
  - Stimulus: all rows = 8'hFF; mute=4'b0101.
  - Required: only trig[1] and trig[3] pulse.
  - Stimulus: write row1=0 on a step-advance cycle.
  - Required: that step still fires trig[1]; the next step does not.
- Loop length:
  - Stimulus: loop_len=3.
  - Required: step_idx sequence 0,1,2,0,…
  - Stimulus: set loop_len=2 while at step 2.
  - Required: the next step is 0.
  - Stimulus: loop_len=0.
  - Required: 8 steps.
- Tempo:
  - Stimulus: bpm_load with bpm=240.
  - Required: period becomes 5 cycles from the next step.
  - Stimulus: bpm_load with bpm=0.
  - Required: period unchanged.
  - Stimulus: bpm=90 (INC=360).
  - Required: periods alternate 13/14 cycles, averaging 13.33.
- Stop and reset:
  - Stimulus: drop play at step 5.
  - Required: next cycle step_idx=0, no trig.
  - Stimulus: assert reset asynchronously mid-step.
  - Required: outputs 0 immediately, the pattern is cleared, and bpm returns to 120.
- Ignored write: wr_chan=CHANNELS with wr_en=1 → no row changes.

Source files
------------

// File: rtl/step_sequencer.sv
// ---------------------------------------------------------------------------
// step_sequencer
//   Multi-channel drum-machine step sequencer. Holds a CHANNELS x STEPS
//   trigger pattern, derives the step rate from a BPM value with a phase
//   accumulator (exact tempo on average) and emits one-cycle trigger pulses
//   at every step start.
//
// Ports
//   clk        system clock (single domain)
//   reset      asynchronous, active-high; clears all state
//   play       level: 1 = run, 0 = stop (stop always rewinds to step 0)
//   bpm        tempo value, captured when bpm_load=1 (0 ignored)
//   bpm_load   capture bpm this cycle
//   wr_en      write one pattern row
//   wr_chan    row to write (values >= CHANNELS ignored)
//   wr_data    row contents, bit s = trigger at step s
//   mute       per-channel mute, sampled on step cycles
//   loop_len   active loop length (0 or > STEPS means STEPS)
//   trig       one-cycle trigger pulses
//   step_idx   current step
//   step_tick  one-cycle pulse at each step start
//   bar_tick   one-cycle pulse when step 0 starts
//   playing    1 while running
// ---------------------------------------------------------------------------
module step_sequencer #(
   parameter int CHANNELS  = 4,
   parameter int STEPS     = 8,
   parameter int CLK_HZ    = 50_000_000,
   parameter int STEP_DIV  = 4,
   parameter int BPM_W     = 8,
   parameter int BPM_RESET = 120
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        play,
   input  logic [BPM_W-1:0]            bpm,
   input  logic                        bpm_load,
   input  logic                        wr_en,
   input  logic [$clog2(CHANNELS)-1:0] wr_chan,
   input  logic [STEPS-1:0]            wr_data,
   input  logic [CHANNELS-1:0]         mute,
   input  logic [$clog2(STEPS):0]      loop_len,
   output logic [CHANNELS-1:0]         trig,
   output logic [$clog2(STEPS)-1:0]    step_idx,
   output logic                        step_tick,
   output logic                        bar_tick,
   output logic                        playing
);

   localparam int SI_W = $clog2(STEPS);
   localparam int LL_W = SI_W + 1;
   localparam int CH_W = $clog2(CHANNELS);
   localparam longint unsigned THRESH  = 64'(CLK_HZ) * 64'd60;
   localparam longint unsigned INC_MAX = ((64'd1 << BPM_W) - 64'd1) * 64'(STEP_DIV);
   // acc stays below THRESH, so acc + INC never exceeds THRESH + INC_MAX
   localparam int ACC_W = $clog2(THRESH + INC_MAX + 64'd1);

   typedef enum logic {S_IDLE = 1'b0, S_PLAY = 1'b1} state_t;

   state_t                           state_q, state_d;
   logic [ACC_W-1:0]                 acc_q, acc_d;
   logic [BPM_W-1:0]                 bpm_q, bpm_d;
   logic [SI_W-1:0]                  step_q, step_d;
   logic [CHANNELS-1:0][STEPS-1:0]   pat_q, pat_d;
   logic [CHANNELS-1:0]              trig_q, trig_d;
   logic                             stick_q, stick_d;
   logic                             btick_q, btick_d;

   logic [ACC_W-1:0]                 inc, acc_sum;
   logic [LL_W-1:0]                  eff_len;
   logic [SI_W-1:0]                  nxt_step, fire_step;
   logic                             fire;

   assign inc     = ACC_W'(bpm_q) * ACC_W'(STEP_DIV);
   assign acc_sum = acc_q + inc;
   assign eff_len = (loop_len == '0 || loop_len > LL_W'(STEPS)) ? LL_W'(STEPS) : loop_len;
   // ">=" rather than "==" so a loop shrunk below the current step wraps next
   assign nxt_step = ({1'b0, step_q} >= eff_len - LL_W'(1)) ? '0 : step_q + SI_W'(1);

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      bpm_d     = bpm_q;
      step_d    = step_q;
      pat_d     = pat_q;
      trig_d    = '0;
      stick_d   = 1'b0;
      btick_d   = 1'b0;
      fire      = 1'b0;
      fire_step = '0;

      case (state_q)
         S_IDLE: begin
            if (play) begin
               state_d   = S_PLAY;
               acc_d     = '0;
               step_d    = '0;
               fire      = 1'b1;
               fire_step = '0;
            end
         end
         default: begin
            if (!play) begin
               // stop rewinds; a step due this cycle is dropped
               state_d = S_IDLE;
               acc_d   = '0;
               step_d  = '0;
            end else if (acc_sum >= ACC_W'(THRESH)) begin
               acc_d     = acc_sum - ACC_W'(THRESH);
               step_d    = nxt_step;
               fire      = 1'b1;
               fire_step = nxt_step;
            end else begin
               acc_d = acc_sum;
            end
         end
      endcase

      // triggers read pat_q, so a same-cycle row write is not seen yet
      for (int c = 0; c < CHANNELS; c++)
         trig_d[c] = fire & pat_q[c][fire_step] & ~mute[c];
      stick_d = fire;
      btick_d = fire && (fire_step == '0);

      if (bpm_load && bpm != '0)
         bpm_d = bpm;

      // out-of-range wr_chan matches no row
      for (int c = 0; c < CHANNELS; c++)
         if (wr_en && wr_chan == CH_W'(c))
            pat_d[c] = wr_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         bpm_q   <= BPM_W'(BPM_RESET);
         step_q  <= '0;
         pat_q   <= '0;
         trig_q  <= '0;
         stick_q <= 1'b0;
         btick_q <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         bpm_q   <= bpm_d;
         step_q  <= step_d;
         pat_q   <= pat_d;
         trig_q  <= trig_d;
         stick_q <= stick_d;
         btick_q <= btick_d;
      end
   end

   assign trig      = trig_q;
   assign step_idx  = step_q;
   assign step_tick = stick_q;
   assign bar_tick  = btick_q;
   assign playing   = (state_q == S_PLAY);

endmodule

// File: tb/tb_step_sequencer.sv
// ---------------------------------------------------------------------------
// tb_step_sequencer
//   Directed bench for step_sequencer with CLK_HZ=80 so that bpm=120 gives a
//   10-cycle step. A second instance with CHANNELS=3 exercises the ignored
//   write to an out-of-range row.
// ---------------------------------------------------------------------------
module tb_step_sequencer;

   logic       clk, reset;
   logic       play, bpm_load, wr_en;
   logic [7:0] bpm, wr_data;
   logic [1:0] wr_chan;
   logic [3:0] mute, loop_len, trig;
   logic [2:0] step_idx;
   logic       step_tick, bar_tick, playing;

   // three-channel instance
   logic       play3, bpm_load3, wr_en3;
   logic [7:0] bpm3;
   logic [1:0] wr_chan3, step_idx3;
   logic [3:0] wr_data3;
   logic [2:0] mute3, loop_len3, trig3;
   logic       step_tick3, bar_tick3, playing3;

   int n_chk = 0;
   int n_fail = 0;
   int cyc;
   int sum;

   step_sequencer #(.CHANNELS(4), .STEPS(8), .CLK_HZ(80), .STEP_DIV(4),
                    .BPM_W(8), .BPM_RESET(120)) u_dut (
      .clk(clk), .reset(reset), .play(play), .bpm(bpm), .bpm_load(bpm_load),
      .wr_en(wr_en), .wr_chan(wr_chan), .wr_data(wr_data), .mute(mute),
      .loop_len(loop_len), .trig(trig), .step_idx(step_idx),
      .step_tick(step_tick), .bar_tick(bar_tick), .playing(playing));

   step_sequencer #(.CHANNELS(3), .STEPS(4), .CLK_HZ(80), .STEP_DIV(4),
                    .BPM_W(8), .BPM_RESET(120)) u_dut3 (
      .clk(clk), .reset(reset), .play(play3), .bpm(bpm3), .bpm_load(bpm_load3),
      .wr_en(wr_en3), .wr_chan(wr_chan3), .wr_data(wr_data3), .mute(mute3),
      .loop_len(loop_len3), .trig(trig3), .step_idx(step_idx3),
      .step_tick(step_tick3), .bar_tick(bar_tick3), .playing(playing3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // cycles until the next step_tick; a 200-cycle bound catches a dead tempo
   task automatic next_step(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!step_tick && n < 200);
   endtask

   task automatic wr_row(input logic [1:0] ch, input logic [7:0] d);
      wr_en = 1'b1; wr_chan = ch; wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_ll[5];
      int exp_p[6];
      exp_ll = '{1, 2, 0, 1, 2};
      exp_p  = '{14, 13, 13, 14, 13, 13};

      reset = 1'b1; play = 1'b0; bpm = 8'd0; bpm_load = 1'b0;
      wr_en = 1'b0; wr_chan = 2'd0; wr_data = 8'd0; mute = 4'd0; loop_len = 4'd0;
      play3 = 1'b0; bpm3 = 8'd120; bpm_load3 = 1'b0; wr_en3 = 1'b0;
      wr_chan3 = 2'd0; wr_data3 = 4'd0; mute3 = 3'd0; loop_len3 = 3'd0;

      // reset state
      #3;
      chk("rst_trig", 32'(trig), 0);
      chk("rst_idx", 32'(step_idx), 0);
      chk("rst_ticks", {30'd0, step_tick, bar_tick}, 0);
      chk("rst_playing", 32'(playing), 0);
      tick();
      reset = 1'b0;
      tick();

      // ignored write: wr_chan=3 on a 3-channel instance
      for (int ch = 0; ch < 3; ch++) begin
         wr_en3 = 1'b1; wr_chan3 = 2'(ch); wr_data3 = 4'b0010;
         tick();
      end
      wr_chan3 = 2'd3; wr_data3 = 4'b0001;
      tick();
      wr_en3 = 1'b0; play3 = 1'b1;
      tick();
      chk("ign_s0_tick", 32'(step_tick3), 1);
      chk("ign_s0_trig", 32'(trig3), 0);
      repeat (10) tick();
      chk("ign_s1_tick", 32'(step_tick3), 1);
      chk("ign_s1_trig", 32'(trig3), 3'b111);
      play3 = 1'b0;
      tick();

      // start and basic stepping
      wr_row(2'd0, 8'b0001_0001);
      play = 1'b1;
      tick();
      chk("start_playing", 32'(playing), 1);
      chk("start_idx", 32'(step_idx), 0);
      chk("start_ticks", {30'd0, step_tick, bar_tick}, 3);
      chk("start_trig", 32'(trig), 4'b0001);
      for (int k = 1; k <= 8; k++) begin
         next_step(cyc);
         chk("a_period", 32'(cyc), 10);
         chk("a_idx", 32'(step_idx), 32'(k % 8));
         chk("a_trig", 32'(trig), (k % 4 == 0) ? 1 : 0);
         chk("a_bar", 32'(bar_tick), (k == 8) ? 1 : 0);
      end
      tick();
      chk("pulse_width", {27'd0, trig, step_tick}, 0);

      // mute and live edit
      play = 1'b0;
      tick();
      chk("stop_playing", 32'(playing), 0);
      for (int ch = 0; ch < 4; ch++) wr_row(2'(ch), 8'hFF);
      mute = 4'b0101; play = 1'b1;
      tick();
      chk("mute_s0", 32'(trig), 4'b1010);
      next_step(cyc);
      chk("mute_s1", 32'(trig), 4'b1010);
      repeat (9) tick();
      wr_en = 1'b1; wr_chan = 2'd1; wr_data = 8'h00;
      tick();
      wr_en = 1'b0;
      chk("edit_same_tick", 32'(step_tick), 1);
      chk("edit_same_trig", 32'(trig), 4'b1010);
      next_step(cyc);
      chk("edit_next_trig", 32'(trig), 4'b1000);
      mute = 4'b0000;

      // loop length
      play = 1'b0;
      tick();
      loop_len = 4'd3; play = 1'b1;
      tick();
      chk("ll_start", 32'(step_idx), 0);
      for (int i = 0; i < 5; i++) begin
         next_step(cyc);
         chk("ll3_idx", 32'(step_idx), 32'(exp_ll[i]));
      end
      loop_len = 4'd2;
      next_step(cyc);
      chk("ll_shrink", 32'(step_idx), 0);
      loop_len = 4'd0;
      for (int k = 1; k <= 8; k++) begin
         next_step(cyc);
         chk("ll0_idx", 32'(step_idx), 32'(k % 8));
      end

      // tempo: load 240 on a step-advance edge
      repeat (9) tick();
      bpm = 8'd240; bpm_load = 1'b1;
      tick();
      bpm_load = 1'b0;
      chk("bpm240_edge", 32'(step_tick), 1);
      for (int i = 0; i < 3; i++) begin
         next_step(cyc);
         chk("bpm240_period", 32'(cyc), 5);
      end
      bpm = 8'd0; bpm_load = 1'b1;
      next_step(cyc);
      bpm_load = 1'b0;
      chk("bpm0_period", 32'(cyc), 5);
      next_step(cyc);
      chk("bpm0_period2", 32'(cyc), 5);
      repeat (4) tick();
      bpm = 8'd90; bpm_load = 1'b1;
      tick();
      bpm_load = 1'b0;
      chk("bpm90_edge", 32'(step_tick), 1);
      sum = 0;
      for (int i = 0; i < 6; i++) begin
         next_step(cyc);
         sum += cyc;
         chk("bpm90_period", 32'(cyc), 32'(exp_p[i]));
      end
      chk("bpm90_sum6", 32'(sum), 80);

      // stop at step 5
      play = 1'b0;
      tick();
      play = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) next_step(cyc);
      chk("stop_at5", 32'(step_idx), 5);
      play = 1'b0;
      tick();
      chk("stop_playing2", 32'(playing), 0);
      chk("stop_idx", 32'(step_idx), 0);
      chk("stop_pulses", {26'd0, trig, step_tick, bar_tick}, 0);

      // asynchronous reset mid-step
      play = 1'b1;
      tick();
      chk("restart_trig", 32'(trig), 4'b1101);
      next_step(cyc);
      chk("pre_rst_idx", 32'(step_idx), 1);
      #2 reset = 1'b1;
      #1;
      chk("arst_idx", 32'(step_idx), 0);
      chk("arst_out", {26'd0, trig, step_tick, bar_tick}, 0);
      chk("arst_playing", 32'(playing), 0);
      play = 1'b0;
      tick();
      reset = 1'b0;
      tick();
      play = 1'b1;
      tick();
      chk("pat_clr_tick", 32'(step_tick), 1);
      chk("pat_clr_trig", 32'(trig), 0);
      next_step(cyc);
      chk("bpm_rst_period", 32'(cyc), 10);
      play = 1'b0;
      tick();

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
